// File: rtl/ccu_sequencer_pkg.sv
// Shared types and constants for the CCU main-control sequencer and its digit timer.
package ccu_sequencer_pkg;

    localparam int DIGITS_DEF       = 36;
    localparam int FETCH_CYCLES_DEF = 2;

    localparam int D_0  = 0;
    localparam int D_1  = 1;
    localparam int D_18 = 18;
    localparam int D_35 = 35;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_ARM   = 2'd1,
        ST_FETCH = 2'd2,
        ST_EXEC  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/ccu_sequencer_digit_timer.sv
// Free-running digit-time counter with minor-cycle parity, digit decodes and wrap strobe.
module ccu_sequencer_digit_timer
    import ccu_sequencer_pkg::*;
#(
    parameter  int DIGITS = DIGITS_DEF,
    localparam int DW     = $clog2(DIGITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [DW-1:0] digit,
    output logic          d0,
    output logic          d1,
    output logic          d18,
    output logic          d35,
    output logic          g1_pos,
    output logic          g1_neg,
    output logic          wrap
);

    localparam logic [DW-1:0] LAST = DW'(DIGITS - 1);

    logic [DW-1:0] digit_q;
    logic          odd_q;

    assign wrap = (digit_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
            odd_q   <= 1'b0;
        end else if (wrap) begin
            digit_q <= '0;
            odd_q   <= ~odd_q;
        end else begin
            digit_q <= digit_q + 1'b1;
        end
    end

    assign digit  = digit_q;
    assign d0     = (digit_q == DW'(D_0));
    assign d1     = (digit_q == DW'(D_1));
    assign d18    = (digit_q == DW'(D_18));
    assign d35    = (digit_q == DW'(D_35));
    assign g1_pos = odd_q;
    assign g1_neg = ~odd_q;

endmodule

// File: rtl/ccu_sequencer.sv
// CCU main-control sequencer: alternates order fetch (Stage 1) and execute (Stage 2) on even minor cycles.
// Optional CCU_SEQ_SINGLE_STEP_EN adds step_mode, which stops the machine after every executed order.
//
//  state    | meaning
//  ST_STOP  | idle, waiting for start
//  ST_ARM   | start accepted, waiting for the next even d0
//  ST_FETCH | Stage 1, FETCH_CYCLES minor cycles (FETCH_CYCLES even, >= 2)
//  ST_EXEC  | Stage 2, one even+odd pair, or until exec_done for long orders
module ccu_sequencer
    import ccu_sequencer_pkg::*;
#(
    parameter  int DIGITS       = DIGITS_DEF,
    parameter  int FETCH_CYCLES = FETCH_CYCLES_DEF,
    localparam int DW           = $clog2(DIGITS)
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef CCU_SEQ_SINGLE_STEP_EN
    input  logic          step_mode,
`endif
    input  logic          start,
    input  logic          stop_order,
    input  logic          order_long,
    input  logic          exec_done,
    output logic [DW-1:0] digit,
    output logic          d0,
    output logic          d1,
    output logic          d18,
    output logic          d35,
    output logic          g1_pos,
    output logic          g1_neg,
    output logic          stage1,
    output logic          stage2,
    output logic          fetch_go,
    output logic          exec_go,
    output logic          order_end,
    output logic          running
);

    localparam int              FCW     = $clog2(FETCH_CYCLES);
    localparam logic [FCW-1:0]  FC_LAST = FCW'(FETCH_CYCLES - 1);

    seq_state_e     state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           entering_q;
    logic           long_q, long_d;
    logic           done_q, done_d;
    logic           stop_q, stop_d;
    logic           wrap;
    logic           is_long, done_now, stop_now, exec_end;
    logic           step_en;

`ifdef CCU_SEQ_SINGLE_STEP_EN
    assign step_en = step_mode;
`else
    assign step_en = 1'b0;
`endif

    ccu_sequencer_digit_timer #(.DIGITS(DIGITS)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .digit  (digit),
        .d0     (d0),
        .d1     (d1),
        .d18    (d18),
        .d35    (d35),
        .g1_pos (g1_pos),
        .g1_neg (g1_neg),
        .wrap   (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_STOP;
            fcnt_q     <= '0;
            entering_q <= 1'b0;
            long_q     <= 1'b0;
            done_q     <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            entering_q <= (state_d != state_q);
            long_q     <= long_d;
            done_q     <= done_d;
            stop_q     <= stop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        long_d   = long_q;
        done_d   = done_q;
        stop_d   = stop_q;
        exec_end = 1'b0;
        // order_long is only meaningful on the first EXEC clock; exec_done only after it
        is_long  = entering_q ? order_long : long_q;
        done_now = done_q | (exec_done & ~entering_q);
        stop_now = stop_q | stop_order;

        case (state_q)
            ST_STOP: begin
                if (start) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (g1_pos && wrap) begin
                    state_d = ST_FETCH;
                    fcnt_d  = '0;
                end
            end
            ST_FETCH: begin
                if (wrap) begin
                    if (fcnt_q == FC_LAST) state_d = ST_EXEC;
                    else                   fcnt_d  = fcnt_q + 1'b1;
                end
            end
            ST_EXEC: begin
                long_d = is_long;
                done_d = is_long & done_now;
                stop_d = stop_now;
                if (g1_pos && wrap && (!is_long || done_now)) begin
                    exec_end = 1'b1;
                    state_d  = (stop_now || step_en) ? ST_STOP : ST_FETCH;
                    fcnt_d   = '0;
                    long_d   = 1'b0;
                    done_d   = 1'b0;
                    stop_d   = 1'b0;
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    assign stage1    = (state_q == ST_FETCH);
    assign stage2    = (state_q == ST_EXEC);
    assign fetch_go  = stage1 & entering_q;
    assign exec_go   = stage2 & entering_q;
    assign order_end = exec_end;
    assign running   = (state_q != ST_STOP);

endmodule
